// File: rtl/antidiff_sequencer.sv
// ---------------------------------------------------------------------------
// antidiff_sequencer
//
// Frame-level controller for an external cascaded-integrator anti-difference
// operator. At frame start it clears the operator. It then accepts one
// difference sample at a time and pulses the operator enable. It waits ORDER
// cycles for the integrator cascade to settle, captures the operator's
// final-stage output and hands it downstream with back-pressure. The last
// result of a frame is tagged with out_last.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   start       begin a frame (looked at in IDLE only)
//   abort       synchronous frame abort, wins over every handshake
//   frame_len   samples per frame, latched on an accepted start
//   in_valid    / in_ready / in_data      difference-sample input handshake
//   op_en       one-cycle operator enable per accepted sample
//   op_y        operator sample input (zero when op_en is low)
//   op_reset    operator synchronous clear, active-high
//   op_out      operator final-stage output
//   out_valid   / out_ready / out_data    result output handshake
//   out_last    marks the final result of the frame
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse when a frame completes normally
// ---------------------------------------------------------------------------
module antidiff_sequencer #(
  parameter int OUT_RES  = 16,
  parameter int ORDER    = 2,
  parameter int LEN_BITS = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [LEN_BITS-1:0] frame_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OUT_RES-1:0]  in_data,
  output logic                op_en,
  output logic [OUT_RES-1:0]  op_y,
  output logic                op_reset,
  input  logic [OUT_RES-1:0]  op_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_RES-1:0]  out_data,
  output logic                out_last,
  output logic                busy,
  output logic                frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCEPT,
    S_SETTLE,
    S_OUTPUT,
    S_DONE
  } state_t;

  // ORDER is at most 15, so a 4-bit settle counter always suffices.
  localparam logic [3:0]          SETTLE_LAST = 4'(ORDER - 1);
  localparam logic [LEN_BITS-1:0] LEN_ONE     = LEN_BITS'(1);

  state_t              state_q, state_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [LEN_BITS-1:0] cnt_q, cnt_d;
  logic [3:0]          settle_q, settle_d;
  logic [OUT_RES-1:0]  out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                frame_done_q, frame_done_d;

  logic abort_act;

  // abort only means something once a frame is running.
  assign abort_act = abort & (state_q != S_IDLE);

  // in_ready is gated by abort so upstream never sees a handshake that the
  // sequencer is about to drop.
  assign in_ready = (state_q == S_ACCEPT) & ~abort;
  assign op_en    = in_ready & in_valid;
  assign op_y     = op_en ? in_data : '0;

  // Combinational so the operator is held clear for the whole time reset is
  // low, not just from the first clock edge after it.
  assign op_reset = ~reset | (state_q == S_CLEAR) | abort_act;

  assign busy       = (state_q != S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    settle_d   = settle_q;
    out_data_d = out_data_q;

    if (abort_act) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            len_d   = frame_len;
            // An empty frame completes without touching the operator.
            state_d = (frame_len == '0) ? S_DONE : S_CLEAR;
          end
        end
        S_CLEAR: begin
          cnt_d   = '0;
          state_d = S_ACCEPT;
        end
        S_ACCEPT: begin
          if (in_valid) begin
            settle_d = '0;
            state_d  = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            // Cascade has settled: capture the final stage verbatim.
            out_data_d = op_out;
            state_d    = S_OUTPUT;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        S_OUTPUT: begin
          if (out_valid_q && out_ready) begin
            cnt_d   = cnt_q + LEN_ONE;
            state_d = out_last_q ? S_DONE : S_ACCEPT;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Output flags are registered copies of the upcoming state, so they are
    // glitch-free and stay stable for as long as OUTPUT is held.
    out_valid_d  = (state_d == S_OUTPUT);
    out_last_d   = (state_d == S_OUTPUT) && (cnt_d == (len_q - LEN_ONE));
    frame_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      settle_q     <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      settle_q     <= settle_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_antidiff_sequencer.sv
// ---------------------------------------------------------------------------
// tb_antidiff_sequencer
//
// Two sequencer instances: A (OUT_RES=16, ORDER=2) and B (OUT_RES=8, ORDER=1),
// each driving a small behavioural cascaded-integrator operator. Stimulus
// pushes hand-computed expected results into a per-instance queue; a monitor
// pops and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_antidiff_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // Instance A signals
  logic        start_a, abort_a, in_valid_a, out_ready_a;
  logic [9:0]  len_a;
  logic [15:0] in_data_a, op_y_a, op_out_a, out_data_a;
  logic        in_ready_a, op_en_a, op_reset_a, out_valid_a, out_last_a;
  logic        busy_a, frame_done_a;

  // Instance B signals
  logic        start_b, abort_b, in_valid_b, out_ready_b;
  logic [9:0]  len_b;
  logic [7:0]  in_data_b, op_y_b, op_out_b, out_data_b;
  logic        in_ready_b, op_en_b, op_reset_b, out_valid_b, out_last_b;
  logic        busy_b, frame_done_b;

  antidiff_sequencer #(.OUT_RES(16), .ORDER(2), .LEN_BITS(10)) dut_a (
    .clk(clk), .reset(reset_n), .start(start_a), .abort(abort_a),
    .frame_len(len_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .op_en(op_en_a), .op_y(op_y_a),
    .op_reset(op_reset_a), .op_out(op_out_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_data(out_data_a), .out_last(out_last_a),
    .busy(busy_a), .frame_done(frame_done_a)
  );

  antidiff_sequencer #(.OUT_RES(8), .ORDER(1), .LEN_BITS(10)) dut_b (
    .clk(clk), .reset(reset_n), .start(start_b), .abort(abort_b),
    .frame_len(len_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .op_en(op_en_b), .op_y(op_y_b),
    .op_reset(op_reset_b), .op_out(op_out_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .out_last(out_last_b),
    .busy(busy_b), .frame_done(frame_done_b)
  );

  // Behavioural order-2 operator for A: stage 1 integrates the sample on
  // op_en, stage 2 integrates stage 1 on the following edge.
  logic [15:0] stg_a [2];
  logic        en_d_a;
  always @(posedge clk) begin
    if (op_reset_a) begin
      stg_a[0] <= '0;
      stg_a[1] <= '0;
      en_d_a   <= 1'b0;
    end else begin
      if (op_en_a) stg_a[0] <= stg_a[0] + op_y_a;
      if (en_d_a)  stg_a[1] <= stg_a[1] + stg_a[0];
      en_d_a <= op_en_a;
    end
  end
  assign op_out_a = stg_a[1];

  // Behavioural order-1 operator for B (8-bit, wraps).
  logic [7:0] stg_b;
  always @(posedge clk) begin
    if (op_reset_b)   stg_b <= '0;
    else if (op_en_b) stg_b <= stg_b + op_y_b;
  end
  assign op_out_b = stg_b;

  // Scoreboard
  typedef struct {
    logic [15:0] data;
    bit          last;
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_cyc_a = 0;
  int op_en_cnt_a = 0;
  int fd_cnt_a = 0;
  logic ov_prev_a = 1'b0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected results on output handshakes, tracks latency and
  // pulse counts for instance A.
  always @(negedge clk) begin
    if (reset_n) begin
      if (op_en_a)      op_en_cnt_a++;
      if (frame_done_a) fd_cnt_a++;
      if (in_valid_a && in_ready_a) hs_cyc_a = cyc;
      if (out_valid_a && !ov_prev_a) check("latency_a", cyc - hs_cyc_a, 3);
      if (out_valid_a && out_ready_a) begin
        if (q_a.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out_a: got 0x%0h, expected none", out_data_a);
        end else begin
          mon_e = q_a.pop_front();
          check("out_data_a", out_data_a, mon_e.data);
          check("out_last_a", out_last_a, mon_e.last);
          $display("[TB] A out data=0x%04h last=%0b (exp 0x%04h/%0b)",
                   out_data_a, out_last_a, mon_e.data, mon_e.last);
        end
      end
      if (out_valid_b && out_ready_b) begin
        if (q_b.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out_b: got 0x%0h, expected none", out_data_b);
        end else begin
          mon_e = q_b.pop_front();
          check("out_data_b", out_data_b, mon_e.data);
          check("out_last_b", out_last_b, mon_e.last);
          $display("[TB] B out data=0x%02h last=%0b (exp 0x%02h/%0b)",
                   out_data_b, out_last_b, mon_e.data[7:0], mon_e.last);
        end
      end
    end
    ov_prev_a = out_valid_a;
  end

  task automatic start_frame(input bit b, input int len);
    @(posedge clk); #1;
    if (b) begin start_b = 1'b1; len_b = 10'(len); end
    else   begin start_a = 1'b1; len_a = 10'(len); end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    // Scribble on frame_len: the latched copy must be unaffected.
    len_a = 10'h3FF;
    len_b = 10'h3FF;
  endtask

  task automatic send(input bit b, input logic [15:0] d, input bit push,
                      input logic [15:0] exp, input bit last);
    exp_t e;
    logic ok;
    e.data = exp;
    e.last = last;
    if (push) begin
      if (b) q_b.push_back(e);
      else   q_a.push_back(e);
    end
    if (b) begin in_valid_b = 1'b1; in_data_b = d[7:0]; end
    else   begin in_valid_a = 1'b1; in_data_a = d; end
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = b ? in_ready_b : in_ready_a;
    end
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    check(b ? "in_handshake_b" : "in_handshake_a", ok, 1);
    $display("[TB] %s in data=0x%04h", b ? "B" : "A", d);
  endtask

  task automatic wait_idle(input bit b);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = !(b ? busy_b : busy_a);
    end
    check(b ? "wait_idle_b" : "wait_idle_a", ok, 1);
  endtask

  task automatic wait_out_valid(input bit b);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = b ? out_valid_b : out_valid_a;
    end
    check(b ? "wait_out_valid_b" : "wait_out_valid_a", ok, 1);
  endtask

  int en_before;

  initial begin
    reset_n = 1'b0;
    start_a = 0; abort_a = 0; in_valid_a = 0; out_ready_a = 1; len_a = 0; in_data_a = 0;
    start_b = 0; abort_b = 0; in_valid_b = 0; out_ready_b = 1; len_b = 0; in_data_b = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out_data", out_data_a, 0);
    check("rst_out_last", out_last_a, 0);
    check("rst_frame_done", frame_done_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_in_ready", in_ready_a, 0);
    check("rst_op_reset", op_reset_a, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_op_reset", op_reset_a, 0);

    // Basic frame: 1,1,1 -> 1,3,6
    start_frame(0, 3);
    send(0, 16'd1, 1, 16'd1, 0);
    send(0, 16'd1, 1, 16'd3, 0);
    send(0, 16'd1, 1, 16'd6, 1);
    wait_idle(0);
    check("fd_cnt_basic", fd_cnt_a, 1);
    check("q_a_empty_basic", q_a.size(), 0);

    // Back-pressure: 5,-2 -> 5,8; first result held 5 cycles
    out_ready_a = 1'b0;
    start_frame(0, 2);
    send(0, 16'd5, 1, 16'd5, 0);
    wait_out_valid(0);
    for (int i = 0; i < 4; i++) begin
      check("bp_data_hold", out_data_a, 16'd5);
      check("bp_valid_hold", out_valid_a, 1);
      check("bp_in_ready", in_ready_a, 0);
      @(posedge clk); #1;
      if (i == 3) out_ready_a = 1'b1;
      @(negedge clk);
    end
    check("bp_data_hold5", out_data_a, 16'd5);
    send(0, 16'hFFFE, 1, 16'd8, 1);
    wait_idle(0);
    check("fd_cnt_bp", fd_cnt_a, 2);

    // Frame restart: residue from the previous frame must be cleared
    start_frame(0, 2);
    send(0, 16'd2, 1, 16'd2, 0);
    send(0, 16'd2, 1, 16'd6, 1);
    wait_idle(0);
    start_frame(0, 1);
    @(negedge clk);
    check("clear_op_reset", op_reset_a, 1);
    send(0, 16'd1, 1, 16'd1, 1);
    wait_idle(0);
    check("fd_cnt_restart", fd_cnt_a, 4);

    // Abort in SETTLE of sample 2 of a 4-sample frame
    start_frame(0, 4);
    send(0, 16'd3, 1, 16'd3, 0);
    send(0, 16'd4, 0, 16'd0, 0);
    abort_a = 1'b1;
    @(negedge clk);
    check("abort_op_reset", op_reset_a, 1);
    @(posedge clk); #1;
    abort_a = 1'b0;
    @(negedge clk);
    check("abort_busy", busy_a, 0);
    check("abort_op_reset_after", op_reset_a, 0);
    repeat (5) @(negedge clk);
    check("abort_no_valid", out_valid_a, 0);
    check("abort_no_done", fd_cnt_a, 4);

    // Abort in ACCEPT with a concurrent input handshake
    start_frame(0, 2);
    @(posedge clk); #1;
    in_valid_a = 1'b1; in_data_a = 16'd9; abort_a = 1'b1;
    @(negedge clk);
    check("abort_acc_op_en", op_en_a, 0);
    check("abort_acc_in_ready", in_ready_a, 0);
    @(posedge clk); #1;
    in_valid_a = 1'b0; abort_a = 1'b0;
    @(negedge clk);
    check("abort_acc_busy", busy_a, 0);

    // start and abort together in IDLE: stay idle
    @(posedge clk); #1;
    start_a = 1'b1; len_a = 10'd3; abort_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; abort_a = 1'b0;
    @(negedge clk);
    check("start_abort_idle", busy_a, 0);

    // Zero-length frame
    en_before = op_en_cnt_a;
    start_frame(0, 0);
    @(negedge clk);
    check("zero_busy", busy_a, 1);
    check("zero_frame_done", frame_done_a, 1);
    @(negedge clk);
    check("zero_busy_after", busy_a, 0);
    check("zero_frame_done_after", frame_done_a, 0);
    check("zero_no_op_en", op_en_cnt_a, en_before);
    check("fd_cnt_zero", fd_cnt_a, 5);

    // Wrap on the 8-bit instance: 100,100 -> 100, 0xC8
    start_frame(1, 2);
    send(1, 16'd100, 1, 16'd100, 0);
    send(1, 16'd100, 1, 16'h00C8, 1);
    wait_idle(1);

    // Async reset during OUTPUT
    out_ready_b = 1'b0;
    start_frame(1, 3);
    send(1, 16'd1, 0, 16'd0, 0);
    wait_out_valid(1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid_b, 0);
    check("arst_busy", busy_b, 0);
    check("arst_out_data", out_data_b, 0);
    check("arst_op_reset", op_reset_b, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready_b = 1'b1;
    start_frame(1, 1);
    send(1, 16'd7, 1, 16'd7, 1);
    wait_idle(1);

    repeat (2) @(negedge clk);
    check("q_a_empty_end", q_a.size(), 0);
    check("q_b_empty_end", q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/antidiff_sequencer.md
Name: antidiff_sequencer

Overview:
- Frame-level controller for the cascaded-integrator anti-difference operator in the recovery datapath.
- Clears the operator at frame start and accepts difference samples over a valid/ready handshake.
- Issues one operator enable per sample, waits for the ORDER-stage cascade to settle, then returns each anti-differenced result downstream with back-pressure.
- Marks the last sample of a frame of configurable length.

Parameters:
OUT_RES, 16, sample/result width in bits (signed two's complement)
ORDER, 2, integrator order of the controlled operator; legal range 1..15
LEN_BITS, 10, width of frame-length configuration

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset
start  in  1  begin a frame; sampled in IDLE only
abort  in  1  synchronous frame abort
frame_len  in  LEN_BITS  samples per frame; latched on accepted start
in_valid  in  1  input sample valid
in_ready  out  1  sequencer can accept sample
in_data  in  OUT_RES  difference sample
op_en  out  1  operator enable (one-cycle pulse per sample)
op_y  out  OUT_RES  operator sample input
op_reset  out  1  operator synchronous clear, active-high
op_out  in  OUT_RES  operator final-stage output
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  OUT_RES  registered anti-differenced result
out_last  out  1  qualifies final result of frame
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse at frame completion

Behaviour:
- FSM states: IDLE, CLEAR, ACCEPT, SETTLE, OUTPUT, DONE. Async reset -> IDLE.
- On reset, all registered outputs are 0: out_data, out_valid, out_last, frame_done, sample count, settle count, latched length.
- op_reset = (~reset) | (state==CLEAR) | (abort & state!=IDLE). Combinational, so the operator is held clear while reset is asserted.
- IDLE:
  - start=1 latches frame_len.
  - If frame_len==0: go to DONE; no operator activity, no outputs.
  - Otherwise: go to CLEAR.
- CLEAR: one cycle with op_reset=1; sample count <= 0; next state ACCEPT.
- ACCEPT:
  - in_ready=1 (in_ready is 0 in all other states).
  - On in_valid&in_ready: op_en=1 and op_y=in_data combinationally in the same cycle; settle count <= 0; next state SETTLE.
  - op_y=0 whenever op_en=0.
- SETTLE:
  - Lasts exactly ORDER cycles.
  - In the last cycle, out_data <= op_out; next state OUTPUT.
  - Latency is fixed: handshake edge to out_valid high = ORDER+1 cycles.
- OUTPUT:
  - out_valid=1; out_last=1 iff sample count == latched length-1.
  - out_data and out_last are held stable until out_ready.
  - On out_valid&out_ready: sample count +1. If last, go to DONE; otherwise go to ACCEPT.
  - out_valid drops the cycle after handshake; no back-to-back results.
- DONE: frame_done=1 for exactly one cycle; next state IDLE.
- abort=1 in any non-IDLE state:
  - Next state IDLE; out_valid, out_last, in_ready cleared; op_reset=1 that cycle.
  - No frame_done pulse.
  - abort has priority over every handshake in the same cycle; a concurrent input handshake is dropped (op_en forced 0).
- start outside IDLE is ignored; start and abort both high in IDLE -> stay IDLE.
- frame_len changes after latching have no effect on the current frame.
- Arithmetic: the sequencer does none; results wrap per operator (modulo 2^OUT_RES), and out_data is a bit-exact copy of op_out.
- Async reset mid-frame: immediate IDLE, outputs 0, operator held clear until reset deasserts.

Test Plan:
- ORDER=2, frame_len=3, inputs 1,1,1, out_ready=1 -> outputs 1,3,6; out_last only on 6; frame_done pulses once; each out_valid rises exactly 3 cycles after its input handshake.
- Back-pressure: frame_len=2, inputs 5,-2, out_ready low 4 cycles on first result -> out_data=5 held stable 5 cycles; in_ready=0 throughout; second output 8 (5+3); out_last on 8.
- Frame restart: run a frame with inputs 2,2, then start a new frame with input 1 -> op_reset pulses in CLEAR; first output of the new frame is 1 (no residue).
- Abort in SETTLE of sample 2 of a 4-sample frame -> IDLE next cycle; op_reset=1 that cycle; no out_valid, no frame_done; busy=0.
- frame_len=0 with start -> busy high 1 cycle, frame_done pulse, op_en never asserted.
- Wrap: OUT_RES=8, ORDER=1, inputs 100,100 -> outputs 100, -56 (0xC8); async reset asserted during OUTPUT -> out_valid=0 immediately, state IDLE.
